// File: rtl/ds_dispatch_queue_pkg.sv
// Shared definitions for the rename->dispatch queue: field widths, entry layout
// and default group/issue widths.
package dispatch_pkg;

    localparam int ALUOP_W    = 9;
    localparam int AREG_W     = 5;
    localparam int PREG_W     = 6;
    localparam int IMM_W      = 32;
    localparam int PC_W       = 32;
    localparam int DS_FIELD_W = ALUOP_W + 3 * AREG_W + 3 * PREG_W + IMM_W;
    localparam int ENTRY_W    = DS_FIELD_W + PC_W;

    localparam int DQ_GROUP_W = 4;
    localparam int DQ_ISSUE_W = 2;

    // pc sits in the low bits so the DS slot fields map straight onto the top.
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic [AREG_W-1:0]  src1;
        logic [AREG_W-1:0]  src2;
        logic [AREG_W-1:0]  rdst;
        logic [PREG_W-1:0]  rsrc1;
        logic [PREG_W-1:0]  rsrc2;
        logic [PREG_W-1:0]  phydst;
        logic [IMM_W-1:0]   imm;
        logic [PC_W-1:0]    pc;
    } dq_entry_t;

    function automatic logic [PC_W-1:0] slot_pc(input logic [PC_W-1:0] base, input int slot);
        return base + PC_W'(4 * slot);
    endfunction

endpackage

// File: rtl/ds_dispatch_queue_compactor.sv
// Maps the valid slots of a dispatch group to their write offsets from tail,
// i.e. offset(i) = number of valid slots below i, plus the total enqueue count.
module dq_compactor
    import dispatch_pkg::*;
#(
    parameter int GROUP_W = DQ_GROUP_W
) (
    input  logic [GROUP_W-1:0]                 valid_i,
    output logic [GROUP_W*$clog2(GROUP_W)-1:0] offs_o,
    output logic [$clog2(GROUP_W+1)-1:0]       n_enq_o
);

    localparam int OFF_W = $clog2(GROUP_W);
    localparam int NE_W  = $clog2(GROUP_W + 1);

    logic [NE_W-1:0] acc_s;

    // Running prefix count of valid slots.
    always_comb begin
        acc_s  = '0;
        offs_o = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            offs_o[i*OFF_W +: OFF_W] = acc_s[OFF_W-1:0];
            acc_s = acc_s + NE_W'(valid_i[i]);
        end
        n_enq_o = acc_s;
    end

endmodule

// File: rtl/ds_dispatch_queue.sv
// In-order dispatch queue: compacts DS groups into a circular buffer and issues
// the two oldest entries in order; stall holds the DS register when space is short.
module ds_dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int GROUP_W = DQ_GROUP_W,
    parameter int ISSUE_W = DQ_ISSUE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [PC_W-1:0]               ds_pc,
    input  logic [GROUP_W-1:0]            ds_valid,
    input  logic [GROUP_W*DS_FIELD_W-1:0] ds_inst,
    output logic                          stall,
    output logic [ISSUE_W-1:0]            iss_valid,
    output logic [ISSUE_W*ENTRY_W-1:0]    iss_inst,
    input  logic [ISSUE_W-1:0]            iss_ready,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(GROUP_W);
    localparam int NE_W  = $clog2(GROUP_W + 1);

    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    dq_entry_t                storage_q [DEPTH];
    dq_entry_t                entry_s   [GROUP_W];
    logic [GROUP_W*OFF_W-1:0] offs_s;
    logic [NE_W-1:0]          n_enq_s;
    logic [CNT_W-1:0]         n_deq_s;
    logic                     stall_s;
    logic                     accept_s;
    logic                     fire_chain_s;

    dq_compactor #(.GROUP_W(GROUP_W)) u_compactor (
        .valid_i (ds_valid),
        .offs_o  (offs_s),
        .n_enq_o (n_enq_s)
    );

    // Stall looks only at registered occupancy, so space freed this cycle is not counted.
    always_comb begin
        stall_s  = ((CNT_W'(DEPTH) - count_q) < CNT_W'(GROUP_W));
        accept_s = !stall_s && !flush && !rst;
    end

    // Build full entries; pc comes from the original slot index, not the compacted position.
    always_comb begin
        for (int i = 0; i < GROUP_W; i++) begin
            entry_s[i] = dq_entry_t'({ds_inst[i*DS_FIELD_W +: DS_FIELD_W], slot_pc(ds_pc, i)});
        end
    end

    // Issue view of the oldest entries and the in-order dequeue count.
    always_comb begin
        iss_valid    = '0;
        iss_inst     = '0;
        n_deq_s      = '0;
        fire_chain_s = 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            iss_valid[i] = (count_q > CNT_W'(i));
            iss_inst[i*ENTRY_W +: ENTRY_W] = storage_q[head_q + PTR_W'(i)];
            fire_chain_s = fire_chain_s & iss_valid[i] & iss_ready[i];
            n_deq_s      = n_deq_s + CNT_W'(fire_chain_s);
        end
    end

    // Pointer and occupancy next state; flush discards everything in flight.
    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d = head_q + PTR_W'(n_deq_s);
            if (accept_s) begin
                tail_d  = tail_q + PTR_W'(n_enq_s);
                count_d = count_q + CNT_W'(n_enq_s) - n_deq_s;
            end else begin
                tail_d  = tail_q;
                count_d = count_q - n_deq_s;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; valid slots land contiguously from tail, wrapping mod DEPTH.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < GROUP_W; i++) begin
                if (ds_valid[i]) begin
                    storage_q[tail_q + PTR_W'(offs_s[i*OFF_W +: OFF_W])] <= entry_s[i];
                end
            end
        end
    end

    assign stall = stall_s;
    assign count = count_q;

endmodule

// File: tb/tb_ds_dispatch_queue.sv
// Self-checking bench for ds_dispatch_queue against a queue-based reference model.
module tb_ds_dispatch_queue;
    import dispatch_pkg::*;

    localparam int DEPTH = 16;
    localparam int GW    = 4;
    localparam int IW    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [31:0]              ds_pc;
    logic [GW-1:0]            ds_valid;
    logic [GW*DS_FIELD_W-1:0] ds_inst;
    logic                     stall;
    logic [IW-1:0]            iss_valid;
    logic [IW*ENTRY_W-1:0]    iss_inst;
    logic [IW-1:0]            iss_ready;
    logic [CW-1:0]            count;

    int total = 0;
    int bad   = 0;
    logic [ENTRY_W-1:0] mq[$];

    ds_dispatch_queue #(.DEPTH(DEPTH), .GROUP_W(GW), .ISSUE_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ds_pc     (ds_pc),
        .ds_valid  (ds_valid),
        .ds_inst   (ds_inst),
        .stall     (stall),
        .iss_valid (iss_valid),
        .iss_inst  (iss_inst),
        .iss_ready (iss_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and advance the reference model across the edge.
    task automatic step(input logic [31:0] pc, input logic [3:0] v, input logic [1:0] rdy,
                        input logic fl, input logic rs);
        int n;
        bit acc;
        ds_pc     = pc;
        ds_valid  = v;
        iss_ready = rdy;
        flush     = fl;
        rst       = rs;
        for (int i = 0; i < GW; i++)
            ds_inst[i*DS_FIELD_W +: DS_FIELD_W] = {10'($urandom), $urandom, $urandom};
        acc = ((DEPTH - mq.size()) >= GW) && !fl && !rs;
        n = 0;
        if (mq.size() > 0 && rdy[0]) n = 1;
        if (n == 1 && mq.size() > 1 && rdy[1]) n = 2;
        repeat (n) void'(mq.pop_front());
        if (acc)
            for (int i = 0; i < GW; i++)
                if (v[i]) mq.push_back({ds_inst[i*DS_FIELD_W +: DS_FIELD_W], pc + 32'(4 * i)});
        if (fl || rs) mq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(32'h0, 4'h0, 2'b00, 1'b0, 1'b1);
        step(32'h0, 4'h0, 2'b00, 1'b0, 1'b1);
        rst = 1'b0;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (iss_valid !== 2'b00) begin bad++; $display("FAIL reset_iss_valid got=%b exp=00", iss_valid); end
    endtask

    task automatic test_basic();
        step(32'h100, 4'b1111, 2'b00, 1'b0, 1'b0);
        total++; if (count !== 5'd4) begin bad++; $display("FAIL basic_count got=%0d exp=4", count); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL basic_stall got=%b exp=0", stall); end
        total++; if (iss_inst[31:0] !== 32'h100) begin bad++; $display("FAIL basic_pc0 got=%h exp=100", iss_inst[31:0]); end
        total++; if (iss_inst[ENTRY_W+31:ENTRY_W] !== 32'h104) begin bad++; $display("FAIL basic_pc1 got=%h exp=104", iss_inst[ENTRY_W+31:ENTRY_W]); end
        total++; if (iss_inst[ENTRY_W-1:0] !== mq[0]) begin bad++; $display("FAIL basic_entry0 got=%h exp=%h", iss_inst[ENTRY_W-1:0], mq[0]); end
        step(32'h200, 4'b1010, 2'b00, 1'b0, 1'b0);
        total++; if (count !== 5'd6) begin bad++; $display("FAIL sparse_count got=%0d exp=6", count); end
    endtask

    task automatic test_handshake();
        step(32'h0, 4'h0, 2'b10, 1'b0, 1'b0);
        total++; if (count !== 5'd6) begin bad++; $display("FAIL hs_lane1_only got=%0d exp=6", count); end
        step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        total++; if (count !== 5'd4) begin bad++; $display("FAIL hs_two_count got=%0d exp=4", count); end
        total++; if (iss_inst[31:0] !== 32'h108) begin bad++; $display("FAIL hs_pc0 got=%h exp=108", iss_inst[31:0]); end
        step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        total++; if (iss_inst[31:0] !== 32'h204) begin bad++; $display("FAIL sparse_pc0 got=%h exp=204", iss_inst[31:0]); end
        total++; if (iss_inst[ENTRY_W+31:ENTRY_W] !== 32'h20C) begin bad++; $display("FAIL sparse_pc1 got=%h exp=20c", iss_inst[ENTRY_W+31:ENTRY_W]); end
        total++; if (iss_inst[2*ENTRY_W-1:ENTRY_W] !== mq[1]) begin bad++; $display("FAIL sparse_entry1 got=%h exp=%h", iss_inst[2*ENTRY_W-1:ENTRY_W], mq[1]); end
        step(32'h0, 4'h0, 2'b01, 1'b0, 1'b0);
        total++; if (iss_valid !== 2'b01) begin bad++; $display("FAIL hs_one_left got=%b exp=01", iss_valid); end
        step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        total++; if (count !== 5'd0) begin bad++; $display("FAIL hs_empty_count got=%0d exp=0", count); end
        total++; if (iss_valid !== 2'b00) begin bad++; $display("FAIL hs_empty_valid got=%b exp=00", iss_valid); end
    endtask

    task automatic test_fill_stall();
        step(32'h0, 4'h0, 2'b00, 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) step(32'h1000 + 32'(16 * g), 4'hF, 2'b00, 1'b0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fill12_stall got=%b exp=0", stall); end
        step(32'h1030, 4'b0001, 2'b00, 1'b0, 1'b0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fill13_stall got=%b exp=1", stall); end
        step(32'h3000, 4'hF, 2'b00, 1'b0, 1'b0);
        total++; if (count !== 5'd13) begin bad++; $display("FAIL stalled_hold got=%0d exp=13", count); end
        step(32'h3000, 4'hF, 2'b01, 1'b0, 1'b0);
        total++; if (count !== 5'd12) begin bad++; $display("FAIL stalled_drain got=%0d exp=12", count); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL drain12_stall got=%b exp=0", stall); end
        step(32'h3000, 4'hF, 2'b00, 1'b0, 1'b0);
        step(32'h3000, 4'hF, 2'b00, 1'b0, 1'b0);
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_once got=%0d exp=16", count); end
        total++; if (iss_valid !== 2'b11) begin bad++; $display("FAIL full_valid got=%b exp=11", iss_valid); end
        step(32'h5000, 4'hF, 2'b11, 1'b0, 1'b0);
        total++; if (count !== 5'd14) begin bad++; $display("FAIL conservative got=%0d exp=14", count); end
        for (int k = 0; k < 64 && mq.size() > 0; k++) begin
            total++;
            if (iss_inst[ENTRY_W-1:0] !== mq[0]) begin bad++; $display("FAIL drain_order k=%0d got=%h exp=%h", k, iss_inst[ENTRY_W-1:0], mq[0]); end
            step(32'h0, 4'h0, 2'($urandom), 1'b0, 1'b0);
        end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL drain_done got=%0d exp=0", count); end
    endtask

    task automatic test_wrap();
        step(32'h0, 4'h0, 2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(32'h2000, 4'hF, 2'b00, 1'b0, 1'b0);
            step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
            step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        end
        step(32'h2100, 4'b0011, 2'b00, 1'b0, 1'b0);
        step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        step(32'h4000, 4'hF, 2'b00, 1'b0, 1'b0);
        total++; if (iss_inst[31:0] !== 32'h4000) begin bad++; $display("FAIL wrap_pc0 got=%h exp=4000", iss_inst[31:0]); end
        total++; if (iss_inst[ENTRY_W+31:ENTRY_W] !== 32'h4004) begin bad++; $display("FAIL wrap_pc1 got=%h exp=4004", iss_inst[ENTRY_W+31:ENTRY_W]); end
        step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        total++; if (iss_inst[31:0] !== 32'h4008) begin bad++; $display("FAIL wrap_pc2 got=%h exp=4008", iss_inst[31:0]); end
        total++; if (iss_inst[ENTRY_W+31:ENTRY_W] !== 32'h400C) begin bad++; $display("FAIL wrap_pc3 got=%h exp=400c", iss_inst[ENTRY_W+31:ENTRY_W]); end
        total++; if (iss_inst[2*ENTRY_W-1:0] !== {mq[1], mq[0]}) begin bad++; $display("FAIL wrap_entries got=%h exp=%h", iss_inst, {mq[1], mq[0]}); end
    endtask

    task automatic test_flush();
        step(32'h6000, 4'hF, 2'b00, 1'b0, 1'b0);
        step(32'h6100, 4'hF, 2'b11, 1'b1, 1'b0);
        total++; if (count !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
        for (int k = 0; k < 4; k++) begin
            total++; if (iss_valid !== 2'b00) begin bad++; $display("FAIL flush_no_issue k=%0d got=%b exp=00", k, iss_valid); end
            step(32'h0, 4'h0, 2'b11, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [1:0] exp_iv;
        for (int c = 0; c < 400; c++) begin
            exp_iv = {mq.size() > 1, mq.size() > 0};
            total++; if (count !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
            total++; if (stall !== ((DEPTH - mq.size()) < GW)) begin bad++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, (DEPTH - mq.size()) < GW); end
            total++; if (iss_valid !== exp_iv) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, iss_valid, exp_iv); end
            for (int l = 0; l < IW; l++)
                if (l < mq.size()) begin
                    total++;
                    if (iss_inst[l*ENTRY_W +: ENTRY_W] !== mq[l]) begin bad++; $display("FAIL rnd_lane%0d c=%0d got=%h exp=%h", l, c, iss_inst[l*ENTRY_W +: ENTRY_W], mq[l]); end
                end
            step($urandom, 4'($urandom), 2'($urandom_range(3, 0) == 0 ? 0 : $urandom),
                 $urandom_range(31, 0) == 0, $urandom_range(79, 0) == 0);
        end
        step(32'h0, 4'hF, 2'b11, 1'b0, 1'b1);
        rst = 1'b0;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL midop_reset got=%0d exp=0", count); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ds_pc = '0; ds_valid = '0; ds_inst = '0; iss_ready = '0;
        test_reset();
        test_basic();
        test_handshake();
        test_fill_stall();
        test_wrap();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
